// File: rtl/mulu.sv
// -----------------------------------------------------------------------------
// mulu -- sequential unsigned radix-2 shift-add multiply-accumulator.
//
// Computes p = a*b + c over W-bit unsigned operands, one multiplier bit per
// clock. It is the inverse datapath of the non-restoring divider: feeding it
// (quotient, divisor, remainder) reconstructs the dividend exactly.
//
// Ports:
//   clk    in   1    rising-edge clock
//   rst_n  in   1    asynchronous active-low reset
//   start  in   1    request; only honoured while busy = 0
//   a      in   W    multiplier, captured with an accepted start
//   b      in   W    multiplicand, captured with an accepted start
//   c      in   W    addend, captured with an accepted start
//   p      out  2W   {hi, lo} register; final result while valid/idle
//   busy   out  1    operation in progress
//   valid  out  1    single-cycle pulse marking p as final
// -----------------------------------------------------------------------------
module mulu #(
   parameter int W = 4096
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   input  logic [W-1:0]   c,
   output logic [2*W-1:0] p,
   output logic           busy,
   output logic           valid
);

   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

   logic [W-1:0]  hi_q,    hi_d;
   logic [W-1:0]  lo_q,    lo_d;
   logic [W-1:0]  rb_q,    rb_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic          busy_q,  busy_d;
   logic          valid_q, valid_d;
   logic [W:0]    sum_s;

   // Next-state logic: operand load when idle, one shift-add step when busy.
   always_comb begin
      hi_d    = hi_q;
      lo_d    = lo_q;
      rb_d    = rb_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      valid_d = 1'b0;
      // Keep the carry: hi + rb can reach 2^(W+1)-2 and its top bit shifts
      // down into hi on this step.
      sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, rb_q} : {(W+1){1'b0}});

      if (busy_q) begin
         hi_d  = sum_s[W:1];
         lo_d  = {sum_s[0], lo_q[W-1:1]};
         cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
         if (cnt_q == CNT_LAST) begin
            busy_d  = 1'b0;
            valid_d = 1'b1;
         end else begin
            busy_d  = 1'b1;
         end
      end else if (start) begin
         // The addend is preloaded into hi so the accumulation is free.
         hi_d   = c;
         lo_d   = a;
         rb_d   = b;
         cnt_d  = {CW{1'b0}};
         busy_d = 1'b1;
      end else begin
         busy_d = 1'b0;
      end
   end

   // State register with asynchronous abort on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q    <= {W{1'b0}};
         lo_q    <= {W{1'b0}};
         rb_q    <= {W{1'b0}};
         cnt_q   <= {CW{1'b0}};
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         rb_q    <= rb_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
      end
   end

   assign p     = {hi_q, lo_q};
   assign busy  = busy_q;
   assign valid = valid_q;

endmodule

// File: tb/tb_mulu.sv
// -----------------------------------------------------------------------------
// tb_mulu -- directed self-checking bench for mulu at W = 8.
// Expected products are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mulu;

   localparam int W = 8;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic [W-1:0]   c;
   logic [2*W-1:0] p;
   logic           busy;
   logic           valid;

   int n_cmp;
   int n_err;

   mulu #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .c     (c),
      .p     (p),
      .busy  (busy),
      .valid (valid)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to 1 ns after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Accept one operation, then check busy/valid every edge and p at E8.
   task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                         input logic [7:0] ic, input logic [15:0] exp);
      start = 1'b1; a = ia; b = ib; c = ic;
      step();                                   // E0
      start = 1'b0; a = 8'h00; b = 8'h00; c = 8'h00;
      check({tag, "_busy_e0"}, {14'd0, busy, valid}, 16'd2);
      for (int i = 1; i <= W; i++) begin
         step();
         if (i < W) check({tag, "_busy_iter"}, {14'd0, busy, valid}, 16'd2);
      end
      check({tag, "_valid_e8"}, {14'd0, busy, valid}, 16'd1);
      check({tag, "_p"}, p, exp);
      step();
      check({tag, "_valid_drop"}, {14'd0, busy, valid}, 16'd0);
      check({tag, "_p_hold"}, p, exp);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      start = 1'b0;
      a = 8'h00; b = 8'h00; c = 8'h00;
      #12;
      check("reset_p", p, 16'h0000);
      check("reset_flags", {14'd0, busy, valid}, 16'd0);
      rst_n = 1'b1;
      step();
      check("idle_flags", {14'd0, busy, valid}, 16'd0);

      // Basic product, carry-out corner, zero multiplier.
      run_op("basic", 8'd13, 8'd11, 8'd7, 16'h0096);
      run_op("maxall", 8'd255, 8'd255, 8'd255, 16'hFF00);
      run_op("a_zero", 8'd0, 8'd200, 8'd99, 16'd99);
      run_op("b_zero", 8'd77, 8'd0, 8'd42, 16'd42);
      run_op("c_zero", 8'd128, 8'd2, 8'd0, 16'd256);

      // Restart attempts while busy are ignored; then start held across valid.
      start = 1'b1; a = 8'd20; b = 8'd30; c = 8'd5;   // 20*30+5 = 605
      step();                                          // E0
      start = 1'b0;
      for (int i = 1; i <= W; i++) begin
         if (i == 3 || i == 7) begin
            start = 1'b1; a = 8'd255; b = 8'd254; c = 8'd253;
         end else if (i == W) begin
            // High before E8 and through E9: ignored at E8, accepted at E9.
            start = 1'b1; a = 8'd100; b = 8'd3; c = 8'd1;  // 301
         end else begin
            start = 1'b0;
         end
         step();
      end
      check("ign_valid", {14'd0, busy, valid}, 16'd1);
      check("ign_p", p, 16'd605);
      step();                                          // E9: accepted
      start = 1'b0; a = 8'h00; b = 8'h00; c = 8'h00;
      check("b2b_busy", {14'd0, busy, valid}, 16'd2);
      for (int i = 1; i < W; i++) step();
      check("b2b_not_yet", {14'd0, busy, valid}, 16'd2);
      step();                                          // E17 = E8 + 9
      check("b2b_valid", {14'd0, busy, valid}, 16'd1);
      check("b2b_p", p, 16'd301);
      step();

      // Asynchronous reset mid-operation.
      start = 1'b1; a = 8'd7; b = 8'd9; c = 8'd3;
      step();
      start = 1'b0;
      for (int i = 1; i <= 4; i++) step();
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_p", p, 16'h0000);
      check("rst_mid_flags", {14'd0, busy, valid}, 16'd0);
      #3 rst_n = 1'b1;
      begin : no_valid_after_reset
         logic seen;
         seen = 1'b0;
         for (int i = 0; i < 12; i++) begin
            step();
            if (valid) seen = 1'b1;
         end
         check("rst_no_valid", {15'd0, seen}, 16'd0);
      end
      run_op("after_rst", 8'd200, 8'd201, 8'd50, 16'd40250);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Hard time limit so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
